// File: rtl/mbox_host_loader_pkg.sv
// mbox_pkg: shared state encoding and mailbox constants for the host loader.
package mbox_pkg;
  typedef enum logic [3:0] {IDLE, LOAD, CLR, ARM, POLL, RK1, RK2, RK3, REL, FIN} state_t;
  localparam logic [7:0] MBOX_CTRL = 8'd0;
  localparam logic [7:0] MBOX_DONE = 8'd1;
  localparam logic [7:0] MBOX_KEY0 = 8'd2;
  localparam logic [7:0] MBOX_KEY1 = 8'd3;
  localparam logic [7:0] MBOX_KEY2 = 8'd4;
  localparam logic [7:0] FLAG_GO = 8'hFF;
  localparam logic [7:0] FLAG_IDLE = 8'h00;
  localparam logic [1:0] TAG_POLL = 2'd3;
endpackage

// File: rtl/mbox_host_loader_rdlat_tag.sv
// rdlat_tag: delays {valid, key-byte index} by the mailbox read latency so returned data can be attributed.
module rdlat_tag #(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_vld,
  input  logic [1:0] i_idx,
  output logic       o_vld,
  output logic [1:0] o_idx
);
  logic       r_vld [LAT];
  logic [1:0] r_idx [LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        r_vld[k] <= 1'b0;
        r_idx[k] <= 2'd0;
      end
    end else begin
      r_vld[0] <= i_vld;
      r_idx[0] <= i_idx;
      for (int k = 1; k < LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_idx[k] <= r_idx[k-1];
      end
    end
  end
  assign o_vld = r_vld[LAT-1];
  assign o_idx = r_idx[LAT-1];
endmodule

// File: rtl/mbox_host_loader.sv
// mbox_host_loader: streams length-prefixed ciphertext into ct_mem, then runs the mailbox
// start/poll/key-read/release handshake with the crack engine.
module mbox_host_loader
  import mbox_pkg::*;
#(
  parameter int          MEM_RD_LAT     = 1,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000,
  parameter int          CNT_W          = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [7:0]  ct_addr,
  output logic [7:0]  ct_wrdata,
  output logic        ct_wren,
  output logic [7:0]  mbox_addr,
  output logic [7:0]  mbox_wrdata,
  output logic        mbox_wren,
  input  logic [7:0]  mbox_rddata,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [23:0] key
);
  state_t           r_st;
  logic [7:0]       r_idx, r_len;
  logic             r_first, r_sent, r_to;
  logic [CNT_W-1:0] r_cnt;
  logic [23:0]      r_key;
  logic             w_xfer, w_last, w_tag_iv, w_tag_ov, w_cap, w_poll_hit, w_to_hit;
  logic [1:0]       w_tag_iidx, w_tag_oidx;
  always_comb begin
    w_xfer      = (r_st == LOAD) && in_valid;
    w_last      = w_xfer && (r_idx == (r_first ? in_data : r_len));
    in_ready    = r_st == LOAD;
    ct_wren     = w_xfer;
    ct_addr     = (r_st == LOAD) ? r_idx : 8'd0;
    ct_wrdata   = w_xfer ? in_data : 8'd0;
    mbox_addr   = (r_st == CLR || r_st == POLL) ? MBOX_DONE :
                  (r_st == RK1) ? MBOX_KEY0 :
                  (r_st == RK2) ? MBOX_KEY1 :
                  (r_st == RK3) ? MBOX_KEY2 : MBOX_CTRL;
    mbox_wren   = r_st inside {CLR, ARM, REL};
    mbox_wrdata = (r_st == ARM) ? FLAG_GO : FLAG_IDLE;
    busy        = r_st != IDLE;
    done        = r_st == FIN;
    // RK3 holds its address while draining; only its first cycle issues a read tag
    w_tag_iv    = (r_st == POLL) || (r_st == RK1) || (r_st == RK2) || (r_st == RK3 && !r_sent);
    w_tag_iidx  = (r_st == POLL) ? TAG_POLL : (r_st == RK1) ? 2'd0 : (r_st == RK2) ? 2'd1 : 2'd2;
    w_cap       = w_tag_ov && (w_tag_oidx != TAG_POLL);
    w_poll_hit  = (r_st == POLL) && w_tag_ov && (w_tag_oidx == TAG_POLL) && (mbox_rddata == FLAG_GO);
    w_to_hit    = (TIMEOUT_CYCLES != 32'd0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 32'd1));
  end
  rdlat_tag #(.LAT(MEM_RD_LAT)) u_tag (
    .clk   (clk),
    .rst   (rst),
    .i_vld (w_tag_iv),
    .i_idx (w_tag_iidx),
    .o_vld (w_tag_ov),
    .o_idx (w_tag_oidx)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st    <= IDLE;
      r_idx   <= 8'd0;
      r_len   <= 8'd0;
      r_first <= 1'b0;
      r_sent  <= 1'b0;
      r_to    <= 1'b0;
      r_cnt   <= '0;
      r_key   <= 24'd0;
    end else begin
      r_sent <= r_st == RK3;
      if (w_cap)
        r_key <= (w_tag_oidx == 2'd0) ? {mbox_rddata, r_key[15:0]} :
                 (w_tag_oidx == 2'd1) ? {r_key[23:16], mbox_rddata, r_key[7:0]} :
                                        {r_key[23:8], mbox_rddata};
      case (r_st)
        IDLE: if (start) begin
          r_st    <= LOAD;
          r_idx   <= 8'd0;
          r_first <= 1'b1;
          r_cnt   <= '0;
          r_key   <= 24'd0;
          r_to    <= 1'b0;
        end
        LOAD: if (w_xfer) begin
          if (r_first) r_len <= in_data;
          r_first <= 1'b0;
          r_idx   <= r_idx + 8'd1;
          if (w_last) r_st <= CLR;
        end
        CLR:  r_st <= ARM;
        ARM:  r_st <= POLL;
        POLL: if (w_poll_hit) r_st <= RK1;
              else if (w_to_hit) begin
                r_to <= 1'b1;
                r_st <= REL;
              end else r_cnt <= r_cnt + 1'b1;
        RK1:  r_st <= RK2;
        RK2:  r_st <= RK3;
        RK3:  if (w_tag_ov && w_tag_oidx == 2'd2) r_st <= REL;
        REL:  r_st <= FIN;
        FIN:  r_st <= IDLE;
        default: r_st <= IDLE;
      endcase
    end
  end
  assign timeout = r_to;
  assign key     = r_key;
endmodule

// File: doc/mbox_host_loader.md
Name: mbox_host_loader

Overview:
Host-side driver for the mailbox crack protocol, sitting directly upstream of the competition top-level. It accepts a length-prefixed ciphertext byte stream and writes it into ct_mem through ct_mem's write port. It then raises the start flag in MBOX[0] and polls MBOX[1] for the done flag. On done it reads the 24-bit key from MBOX[2..4] and releases the handshake by writing MBOX[0]=0x00.

Parameters:
MEM_RD_LAT, 1, read latency in cycles from address to q for mbox (and ct_mem), range 1..2
TIMEOUT_CYCLES, 32'd100_000_000, POLL cycles before abort; 0 disables the timeout
CNT_W, 32, width of the timeout counter

Ports:
clk  in  1  system clock (CLOCK_115 domain)
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a load/crack session; honoured only in IDLE
in_valid  in  1  ciphertext stream byte valid
in_data  in  8  ciphertext stream byte; first byte is the length L, then L message bytes
in_ready  out  1  loader accepts in_data this cycle (valid & ready = transfer)
ct_addr  out  8  ct_mem address
ct_wrdata  out  8  ct_mem write data
ct_wren  out  1  ct_mem write enable
mbox_addr  out  8  mbox address
mbox_wrdata  out  8  mbox write data
mbox_wren  out  1  mbox write enable
mbox_rddata  in  8  mbox q
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the session ends (key or timeout)
timeout  out  1  sticky; set on abort, cleared on next accepted start
key  out  24  registered key {MBOX[2],MBOX[3],MBOX[4]}; holds until next accepted start

Behaviour:
- Reset: state IDLE, all outputs 0, byte count 0, timeout counter 0. A reset mid-session abandons the session with no release write.
- IDLE: in_ready=0, mbox_addr=0, no writes. start=1 goes to LOAD and clears key and timeout.
- LOAD: in_ready=1. Each transfer writes in_data to ct_mem[idx] with ct_wren=1 in the same cycle, then idx increments (8-bit).
  - The first byte latches L.
  - Leaves LOAD after the write at idx==L, so L+1 writes total. L=0 means one write. L=255 means 256 writes ending at address 0xFF, with no wrap past it.
  - in_valid=0 stalls with no writes.
- CLR: one cycle writing MBOX[1]=0x00. This clears a stale done flag.
- ARM: one cycle writing MBOX[0]=0xFF.
- POLL: mbox_addr=1, no write.
  - Compare mbox_rddata only after MEM_RD_LAT cycles in POLL.
  - 0xFF goes to RK1.
  - Timeout counter increments each POLL cycle. Reaching TIMEOUT_CYCLES (if nonzero) sets timeout and goes to REL.
- RK1/RK2/RK3: present addresses 2, 3, 4 on consecutive cycles, pipelined. Capture key[23:16], key[15:8], key[7:0] from mbox_rddata MEM_RD_LAT cycles after each address, with a drain wait as needed. Total key read is 3+MEM_RD_LAT cycles.
- REL: one cycle writing MBOX[0]=0x00. The competition top returns to IDLE on seeing it.
- FIN: done=1 for one cycle, then IDLE.
- busy=1 in all states except IDLE.
- start in any non-IDLE state is ignored.
- At most one of ct_wren or mbox_wren is high in any cycle.
- Writes are combinational from state; addresses and data are stable in the write cycle.

Decomposition:
- Shared package mbox_pkg:
  - state enum (IDLE, LOAD, CLR, ARM, POLL, RK1, RK2, RK3, REL, FIN)
  - mailbox address constants MBOX_CTRL=0, MBOX_DONE=1, MBOX_KEY0=2, MBOX_KEY1=3, MBOX_KEY2=4
  - flag constants FLAG_GO=8'hFF, FLAG_IDLE=8'h00
- One natural sub-module, rdlat_tag: a MEM_RD_LAT-deep shift register carrying {valid, key-byte index}. It aligns returned mbox_rddata with the address that requested it, in both POLL and RK states.

Test Plan:
1. Stream L=3, bytes A1 B2 C3 with in_valid always high -> ct_mem[0..3] = 03 A1 B2 C3, exactly 4 ct_wren cycles; then one write MBOX[1]=00, then one write MBOX[0]=FF.
2. Responder model sets MBOX[2..4]=1A 2B 3C, then MBOX[1]=FF, 50 cycles after arm -> key=24'h1A2B3C, then one write MBOX[0]=00, then one done pulse; timeout=0. Run with MEM_RD_LAT=1 and MEM_RD_LAT=2.
3. Stream L=0 with in_valid toggling 1/0 -> a single write ct_mem[0]=00; no writes while in_valid=0; ARM follows.
4. Stream L=255 -> 256 writes, last at address 0xFF, ct_addr never wraps to 0 for a write; correct state after.
5. TIMEOUT_CYCLES=20, responder never writes MBOX[1] -> after 20 POLL cycles timeout=1, MBOX[0]=00 written, done pulse, key=0. A following start clears timeout.
6. Assert rst during POLL -> next cycle all outputs 0, state IDLE. start pulsed during LOAD -> ignored with no state change; stale MBOX[1]=FF before a session -> cleared by the CLR write, so no early key read.
